// File: rtl/output_decision_filter_if.sv
// Decision bus between the frequency detector's final stage and the LED filter.
// The detector (master) drives the class code and its strobe. The filter (slave)
// returns the LED pattern and the confirmed-class status.
interface output_decision_filter_if #(
  parameter int ANSWER_W = 3,
  parameter int LIGHT_W  = 4
);
  logic [ANSWER_W-1:0] finalAnswer;
  logic                finalDone;
  logic [LIGHT_W-1:0]  lightOut;
  logic [ANSWER_W-1:0] currentClass;
  logic                classValid;
  logic                changed;

  modport master (
    output finalAnswer, finalDone,
    input  lightOut, currentClass, classValid, changed
  );

  modport slave (
    input  finalAnswer, finalDone,
    output lightOut, currentClass, classValid, changed
  );
endinterface

// File: rtl/output_decision_filter.sv
// Debounces detector class decisions and maps the confirmed class onto LEDs.
// When decisions stop arriving for TIMEOUT_CYCLES clocks, the display blinks
// until the next confirmation.
module output_decision_filter #(
  parameter int NUM_CLASSES    = 4,
  parameter int ANSWER_W       = 3,
  parameter int LIGHT_W        = 4,
  parameter int CONFIRM_COUNT  = 3,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BLINK_HALF     = 250000
) (
  input  logic                      clock,
  input  logic                      resetN,
  output_decision_filter_if.slave   bus
);
  localparam int CW = $clog2(CONFIRM_COUNT + 1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {IDLE, SHOW, STALE} state_t;

  state_t              state;
  logic [ANSWER_W-1:0] cand;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idle_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                blink_on;   // STALE phase: 1 = pattern shown, 0 = dark

  logic          match;
  logic          confirm;
  logic          timeout_hit;
  logic          blink_tick;
  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idle_nxt;

  // Code 0 lights everything, 1..NUM_CLASSES light one LED, anything else is dark.
  function automatic logic [LIGHT_W-1:0] pattern(input logic [ANSWER_W-1:0] c);
    logic [LIGHT_W-1:0] p;
    p = '0;
    if (c == '0) p = '1;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (c == ANSWER_W'(i + 1)) p[i] = 1'b1;
    return p;
  endfunction

  // Debounce, timeout and blink decode for the current cycle.
  always_comb begin
    match   = (bus.finalAnswer == cand);
    cnt_nxt = CW'(1);
    if (match) cnt_nxt = (cnt == CW'(CONFIRM_COUNT)) ? cnt : cnt + 1'b1;
    // Only the decision that lands exactly on CONFIRM_COUNT confirms. A
    // saturated repeat does not re-confirm. With a count of one, every
    // decision updates the display.
    confirm = bus.finalDone &&
              ((CONFIRM_COUNT == 1) || (match && cnt == CW'(CONFIRM_COUNT - 1)));
    idle_nxt    = (idle_cnt == IW'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state == SHOW) && !bus.finalDone &&
                  (idle_nxt == IW'(TIMEOUT_CYCLES));
    blink_tick  = (blink_cnt == BW'(BLINK_HALF - 1));
  end

  // Display state machine. Confirmation takes priority over timeout and blink.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      cand             <= '0;
      cnt              <= '0;
      idle_cnt         <= '0;
      blink_cnt        <= '0;
      blink_on         <= 1'b0;
      bus.lightOut     <= '0;
      bus.currentClass <= '0;
      bus.classValid   <= 1'b0;
      bus.changed      <= 1'b0;
    end else begin
      bus.changed <= 1'b0;
      if (bus.finalDone) begin
        cand <= bus.finalAnswer;
        cnt  <= cnt_nxt;
      end
      if (confirm) begin
        state            <= SHOW;
        bus.currentClass <= bus.finalAnswer;
        bus.lightOut     <= pattern(bus.finalAnswer);
        bus.classValid   <= (bus.finalAnswer <= ANSWER_W'(NUM_CLASSES));
        bus.changed      <= (state == IDLE) || (bus.finalAnswer != bus.currentClass);
        idle_cnt         <= '0;
        blink_cnt        <= '0;
        blink_on         <= 1'b0;
      end else begin
        if (state != IDLE && TIMEOUT_CYCLES != 0)
          idle_cnt <= bus.finalDone ? '0 : idle_nxt;
        if (timeout_hit) begin
          state        <= STALE;
          cnt          <= '0;
          bus.lightOut <= '0;
          blink_cnt    <= '0;
          blink_on     <= 1'b0;
        end else if (state == STALE) begin
          if (blink_tick) begin
            blink_cnt    <= '0;
            blink_on     <= ~blink_on;
            bus.lightOut <= blink_on ? '0 : pattern(bus.currentClass);
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/output_decision_filter.md
# output_decision_filter

Parametrised successor to the tone-classifier light driver. It takes the final class index and its valid strobe from the frequency detector and debounces the class over consecutive decisions. It maps the confirmed class onto a one-hot or all-on LED pattern, and blinks the display when detector results stop arriving. It sits between the detector's final decision stage and the board LEDs.

## Interface
- NUM_CLASSES, 4: number of tone classes; codes 1..NUM_CLASSES each drive one LED.
- ANSWER_W, 3: width of the class code; must satisfy 2^ANSWER_W > NUM_CLASSES.
- LIGHT_W, 4: LED count; must be ≥ NUM_CLASSES.
- CONFIRM_COUNT, 3: identical consecutive decisions required to change the display; ≥1.
- TIMEOUT_CYCLES, 1000000: idle clocks without finalDone before the display goes stale; 0 disables the timeout.
- BLINK_HALF, 250000: half-period of the stale blink, in clocks; ≥1.
- clock  input  1  single clock, rising edge.
- resetN  input  1  reset; asynchronous assert, active-low.
- finalAnswer  input  ANSWER_W  class code; 0 means no tone, 1..NUM_CLASSES are tones, higher codes are invalid.
- finalDone  input  1  finalAnswer is valid this cycle; single- or multi-cycle high; each high cycle counts as one decision.
- lightOut  output  LIGHT_W  LED pattern (registered).
- currentClass  output  ANSWER_W  confirmed class code (registered).
- classValid  output  1  high when the confirmed code is ≤ NUM_CLASSES and a class has been confirmed.
- changed  output  1  one-cycle pulse when the confirmed class changes.

## Operation
- States:
  - IDLE: after reset; nothing confirmed; lightOut = 0.
  - SHOW: a class is confirmed and displayed steadily.
  - STALE: timeout has expired; display blinks.
- Pattern map:
  - code 0 → all LIGHT_W bits set.
  - code c in 1..NUM_CLASSES → only bit c-1 set.
  - any other code → all bits clear; classValid = 0.
- Debounce: the block keeps a candidate register and a count, width clog2(CONFIRM_COUNT+1). On each cycle with finalDone high:
  - If finalAnswer equals the candidate, count increments and saturates at CONFIRM_COUNT.
  - Otherwise the candidate is set to finalAnswer and count is set to 1.
- Confirmation occurs on the decision that brings count to exactly CONFIRM_COUNT. Further repeats of the same code do not re-confirm.
  - On confirmation, currentClass is set to the candidate, lightOut is set to pattern(candidate), and the state becomes SHOW.
  - changed pulses if the state was IDLE or the new code differs from currentClass.
- With CONFIRM_COUNT = 1, every finalDone updates the display. This reproduces the previous-generation behaviour.
- Idle counter: cleared on every finalDone cycle; otherwise increments, saturating. It is active only in SHOW and STALE, and only when TIMEOUT_CYCLES ≠ 0.
- SHOW → STALE: when the idle counter reaches TIMEOUT_CYCLES.
  - The candidate count is cleared.
  - The blink counter starts.
  - lightOut is driven to 0 on entry.
- STALE blink: every BLINK_HALF clocks, lightOut toggles between 0 and pattern(currentClass). currentClass and classValid hold their values.
- STALE → SHOW: on the next confirmation, including a confirmation of the same class.
  - lightOut goes steady.
  - changed pulses only if the class differs.
- IDLE never times out.

## Timing
- All outputs are registered. Reset values:
  - lightOut = 0
  - currentClass = 0
  - classValid = 0
  - changed = 0
  - state = IDLE
  - all counters 0
- Latency: a confirming finalDone sampled at rising edge k produces the new lightOut, currentClass, classValid and changed values at edge k. These are visible for cycle k+1. changed deasserts at edge k+1.
- Simultaneous timeout expiry and finalDone: finalDone wins. The idle counter clears and there is no STALE entry.
- Confirmation in the same cycle as a blink toggle: confirmation wins; lightOut shows the steady pattern.
- resetN low at any time, including mid-blink or mid-count, forces all reset values immediately (asynchronously). Operation resumes on the first rising edge after deassertion.

## Test plan
Parameters for all scenarios: CONFIRM_COUNT=3, TIMEOUT_CYCLES=20, BLINK_HALF=4, NUM_CLASSES=4, LIGHT_W=4.
- Reset: hold resetN low → lightOut=0000, currentClass=0, classValid=0, changed=0.
- Debounce: finalAnswer=2 with three finalDone pulses, gaps allowed → lightOut=0000 after two pulses; after the third, lightOut=0010, currentClass=2, classValid=1, changed high for exactly one cycle.
- Restart: sequence 2,2,3,2,2 → no change; one more 2 → lightOut=0010.
- Special codes: 0 ×3 → lightOut=1111, classValid=1; then 6 ×3 → lightOut=0000, classValid=0, changed pulses.
- Timeout:
  - Confirm 4 → lightOut=1000.
  - No finalDone for 20 cycles → lightOut=0000 for 4 cycles, then 1000 for 4, repeating.
  - Then 4 ×3 → steady 1000, no changed pulse.
- Async reset mid-blink: drop resetN between clock edges → lightOut=0000 before the next edge; state returns to IDLE.
